// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ          = 8;
    localparam int unsigned SEL_W          = 3;
    localparam int unsigned MAX_HOLD_LIMIT = 15;

    typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between requesters and the mux arbiter.
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;

    modport master (output en, req, input gnt, sel, sel_valid, busy);
    modport slave  (input en, req, output gnt, sel, sel_valid, busy);

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 7->0.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] j;

    // Scan from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = ptr + SEL_W'(i);
            if (req[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of an external 8:1 mux, with bounded hold time.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > MAX_HOLD_LIMIT) begin : g_bad_hold
        $error("mux_rr_arbiter: MAX_HOLD must be within 1..15");
    end

    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    logic             rel;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;

    assign rel      = (state_q == GRANT) && (!bus.req[sel_q] || cnt_q == HOLD);
    // On release the picker already sees the advanced pointer, so there is no bubble.
    assign pick_ptr = rel ? sel_q + 3'd1 : ptr_q;

    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en && win_found) begin
                    state_d = GRANT;
                    gnt_d   = idx_to_onehot(win_idx);
                    sel_d   = win_idx;
                    cnt_d   = 4'd1;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d = pick_ptr;
                    if (bus.en && win_found) begin
                        gnt_d = idx_to_onehot(win_idx);
                        sel_d = win_idx;
                        cnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        sel_d   = '0;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = |gnt_q;
    assign bus.busy      = (state_q == GRANT);

endmodule
